// File: rtl/cfu_pkg.sv
// Shared CFU definitions: datapath widths, tile scheduler state encoding and
// the CFU command function codes.
package cfu_pkg;

    localparam int unsigned K_W = 11;
    localparam int unsigned M_W = 12;
    localparam int unsigned N_W = 9;
    localparam int unsigned A_W = 15;
    localparam int unsigned B_W = 14;
    localparam int unsigned C_W = 13;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_BUSY  = 3'd3,
        ADVANCE    = 3'd4,
        DONE       = 3'd5
    } sched_state_t;

    localparam logic [6:0] FUNC_RESET     = 7'd0;
    localparam logic [6:0] FUNC_SET_KMN   = 7'd1;
    localparam logic [6:0] FUNC_SET_OFS   = 7'd2;
    localparam logic [6:0] FUNC_START     = 7'd3;
    localparam logic [6:0] FUNC_STATUS    = 7'd4;
    localparam logic [6:0] FUNC_ABORT     = 7'd5;
    localparam logic [6:0] FUNC_WRITE_BUF = 7'd6;
    localparam logic [6:0] FUNC_READ_BUF  = 7'd7;

endpackage

// File: rtl/tile_scheduler.sv
// Splits a K x M x N matrix multiply into TILE_M x TILE_N tiles (m outer,
// n inner), issuing one TPU start per tile and publishing A/B/C base offsets.
module tile_scheduler
    import cfu_pkg::*;
#(
    parameter int unsigned TILE_M = 128,
    parameter int unsigned TILE_N = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [10:0] job_K,
    input  logic [11:0] job_M,
    input  logic [8:0]  job_N,
    input  logic [31:0] job_offset,
    input  logic        abort,
    output logic        tpu_in_valid,
    output logic [10:0] tpu_K,
    output logic [11:0] tpu_M,
    output logic [8:0]  tpu_N,
    output logic [31:0] tpu_offset,
    input  logic        tpu_busy,
    output logic [14:0] a_base,
    output logic [13:0] b_base,
    output logic [12:0] c_base,
    output logic        done_valid,
    input  logic        done_ready,
    output logic        done_aborted,
    output logic [15:0] tiles_done
);

    localparam logic [M_W-1:0] TM = M_W'(TILE_M);
    localparam logic [N_W-1:0] TN = N_W'(TILE_N);

    sched_state_t state, state_next;

    // Remaining rows/cols from the current tile onward stand in for mi/ni,
    // so tile sizes come from a subtract-and-compare instead of a multiply.
    logic [M_W-1:0] m_rem, m_rem_after, tm_after;
    logic [N_W-1:0] n_rem, n_rem_after, tn_after, n_total, tn_first;
    logic [A_W-1:0] sa;
    logic [B_W-1:0] sb;
    logic [7:0]     tn_words;
    logic [C_W-1:0] c_inc;
    logic           last_m, last_n, last_tile, job_empty, accept;

    assign m_rem_after = m_rem - TM;
    assign tm_after    = (m_rem_after < TM) ? m_rem_after : TM;
    assign n_rem_after = n_rem - TN;
    assign tn_after    = (n_rem_after < TN) ? n_rem_after : TN;
    assign tn_first    = (n_total < TN) ? n_total : TN;
    assign last_m      = (m_rem <= TM);
    assign last_n      = (n_rem <= TN);
    assign last_tile   = last_m && last_n;
    assign tn_words    = 8'((10'(tpu_N) + 10'd3) >> 2);
    assign c_inc       = C_W'(20'(tpu_M) * 20'(tn_words));
    assign job_empty   = (job_K == '0) || (job_M == '0) || (job_N == '0);
    assign accept      = job_valid && job_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        job_ready    = 1'b0;
        tpu_in_valid = 1'b0;
        done_valid   = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_next = job_empty ? DONE : ISSUE;
            end
            ISSUE: begin
                tpu_in_valid = 1'b1;
                state_next   = WAIT_START;
            end
            WAIT_START: state_next = WAIT_BUSY;
            WAIT_BUSY:  if (!tpu_busy) state_next = ADVANCE;
            ADVANCE:    state_next = (last_tile || abort) ? DONE : ISSUE;
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpu_K        <= '0;
            tpu_M        <= '0;
            tpu_N        <= '0;
            tpu_offset   <= '0;
            a_base       <= '0;
            b_base       <= '0;
            c_base       <= '0;
            tiles_done   <= '0;
            done_aborted <= 1'b0;
            m_rem        <= '0;
            n_rem        <= '0;
            n_total      <= '0;
            sa           <= '0;
            sb           <= '0;
        end else if (accept) begin
            tpu_K        <= job_K;
            tpu_M        <= (job_M < TM) ? job_M : TM;
            tpu_N        <= (job_N < TN) ? job_N : TN;
            tpu_offset   <= job_offset;
            a_base       <= '0;
            b_base       <= '0;
            c_base       <= '0;
            tiles_done   <= '0;
            done_aborted <= 1'b0;
            m_rem        <= job_M;
            n_rem        <= job_N;
            n_total      <= job_N;
            sa           <= A_W'(32'(job_K) * 32'(TILE_M / 4));
            sb           <= B_W'(32'(job_K) * 32'(TILE_N / 4));
        end else if (state == ADVANCE) begin
            tiles_done <= tiles_done + 16'd1;
            c_base     <= c_base + c_inc;
            if (!last_n) begin
                n_rem  <= n_rem_after;
                tpu_N  <= tn_after;
                b_base <= b_base + sb;
            end else begin
                n_rem  <= n_total;
                tpu_N  <= tn_first;
                b_base <= '0;
                m_rem  <= m_rem_after;
                tpu_M  <= tm_after;
                a_base <= a_base + sa;
            end
            if (last_tile || abort) done_aborted <= abort && !last_tile;
        end
    end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Sequences the TPU over a matrix multiply larger than one TPU pass. It accepts a job (K, M, N, input offset) from the CFU command FSM and splits M and N into tiles of at most TILE_M × TILE_N, with K kept whole. For each tile it issues one TPU start and publishes base offsets for the A, B and C global buffers, which the integrating Cfu adds to the TPU's buffer indices. It sits between the Cfu command decode and the `TPU` instance.

## Interface
- TILE_M, default 128, max rows per tile; multiple of 4, at most 4095.
- TILE_N, default 128, max cols per tile; multiple of 4, at most 511.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_K  in  11  reduction depth.
- job_M  in  12  rows.
- job_N  in  9  cols.
- job_offset  in  32  input offset, passed unchanged to the TPU.
- abort  in  1  level; stop after the current tile.
- tpu_in_valid  out  1  one-cycle TPU start pulse.
- tpu_K  out  11  tile K (always job K).
- tpu_M  out  12  tile rows.
- tpu_N  out  9  tile cols.
- tpu_offset  out  32  registered job_offset.
- tpu_busy  in  1  TPU busy.
- a_base  out  15  A word offset of the current tile.
- b_base  out  14  B word offset of the current tile.
- c_base  out  13  C 128-bit-entry offset of the current tile.
- done_valid  out  1  job finished.
- done_ready  in  1  done acknowledge.
- done_aborted  out  1  job ended by abort; valid with done_valid.
- tiles_done  out  16  tiles completed in the current or last job.

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_BUSY, ADVANCE, DONE.
- IDLE
  - A job is accepted when job_valid && job_ready.
  - On accept, register K, M, N and offset; clear mi, ni, the bases and tiles_done.
  - Compute the strides once: SA = K*TILE_M/4 and SB = K*TILE_N/4, each truncated to its base width.
  - If K, M or N is 0: go to DONE, done_aborted=0, no TPU pulse. Otherwise go to ISSUE.
- Tile sizes
  - tm = min(TILE_M, M − mi*TILE_M).
  - tn = min(TILE_N, N − ni*TILE_N).
- ISSUE: tpu_in_valid=1 for exactly this cycle, with tpu_M=tm and tpu_N=tn. Go to WAIT_START.
- WAIT_START: exactly one cycle, with tpu_busy ignored. Go to WAIT_BUSY.
- WAIT_BUSY: hold while tpu_busy=1. When tpu_busy=0, go to ADVANCE.
- ADVANCE
  - tiles_done += 1.
  - c_base += tm*ceil(tn/4).
  - Loop order is m outer, n inner: ni += 1 and b_base += SB.
  - When ni wraps: ni=0, b_base=0, mi += 1, a_base += SA.
  - If the last tile is finished, or abort=1 in this cycle: go to DONE, with done_aborted = abort && !last.
  - Otherwise go to ISSUE.
- DONE: done_valid=1. On done_ready, go to IDLE.
- abort is sampled only in ADVANCE. An in-flight tile always completes.
- All base arithmetic wraps modulo 2^width, with no saturation. Keeping buffers in range is the host's responsibility.
- tpu_M, tpu_N, tpu_K and the bases are registered and stable from ISSUE through ADVANCE.

## Timing
- Reset values:
  - state IDLE.
  - tpu_in_valid, done_valid and done_aborted are 0.
  - All bases, tpu_M/N/K, tpu_offset and tiles_done are 0.
  - job_ready=1.
- Job accept to first tpu_in_valid: 1 cycle (ISSUE is entered on the edge after accept).
- Per-tile overhead outside TPU busy: ISSUE + WAIT_START + ADVANCE = 3 cycles, plus at least 1 cycle in WAIT_BUSY.
- Falling edge of tpu_busy to the next tpu_in_valid: 2 cycles (ADVANCE, then ISSUE).
- job_valid is ignored outside IDLE, with no queueing.
- done_valid is held until done_ready; back-to-back jobs need one IDLE cycle.
- Reset mid-job returns the block to IDLE immediately. The TPU is reset by the same rst_n.

## Structure
- Shared package `cfu_pkg`:
  - K/M/N and A/B/C index widths (11, 12, 9, 15, 14, 13).
  - The FSM state encoding.
  - The func_* command codes.
- No sub-module; a single flat module. The strides use one constant multiply each, and the c_base increment uses one small multiply (12×7).

## Test plan
- K=64, M=100, N=50 → one pulse with tpu_M=100, tpu_N=50, all bases 0; tiles_done=1; done_aborted=0.
- K=16, M=200, N=160 → 4 tiles in order, bases (a,b,c) as below; tiles_done=4.
  - (128,128): 0, 0, 0.
  - (128,32): 0, 512, 4096.
  - (72,128): 512, 0, 5120.
  - (72,32): 512, 512, 7424.
- M=0 → done_valid 1 cycle after accept, no tpu_in_valid, tiles_done=0.
- Same job as the second case with abort asserted during tile 2's busy → tile 2 completes, no third pulse, done_aborted=1, tiles_done=2.
- done_ready held low for 10 cycles, with job_valid pulsed in DONE → done_valid stays 1, job_ready=0, second job not accepted.
- rst_n low during WAIT_BUSY → next cycle all outputs at reset values; a new job then starts with bases 0.
